// File: rtl/axi_read_burst_ctrl.sv
// AXI4 INCR read master streaming a byte-counted memory region as bytes.
// Optional `AXI_RD_RLAST_CHECK_EN: treat misplaced rlast as a read error.
module axi_read_burst_ctrl #(
  parameter int MAX_BEATS = 256,
  parameter int BOUNDARY  = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [31:0] num_bytes,
  output logic        done,
  output logic        error,
  output logic [7:0]  data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state;
  logic [31:0] addr;
  logic [31:0] rem;
  logic [31:0] bbuf;
  logic [1:0]  off;
  logic [1:0]  lane;
  logic [2:0]  cnt;
  logic [8:0]  bcnt;
  logic [8:0]  blen;
  logic        err;

  logic [31:0] aligned;
  logic [33:0] need;
  logic [31:0] room;
  logic [8:0]  beats;
  logic [2:0]  avail;
  logic [2:0]  nbytes;
  logic        take_byte;
  logic        last_byte;
  logic        take_beat;
  logic        bad;

  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign aligned = {addr[31:2], 2'b00};

  always_comb begin
    need  = ({2'b00, rem} + {32'd0, off} + 34'd3) >> 2;
    room  = (32'(BOUNDARY) - (aligned & 32'(BOUNDARY - 1))) >> 2;
    beats = 9'(MAX_BEATS);
    if (need < {25'd0, beats})
      beats = need[8:0];
    if (room < {23'd0, beats})
      beats = room[8:0];
  end

  // rem only counts bytes not yet captured, so the final beat trims here
  assign avail  = 3'd4 - {1'b0, off};
  assign nbytes = (rem < {29'd0, avail}) ? rem[2:0] : avail;

  assign data_valid = cnt != 3'd0;
  assign data_out   = bbuf[{lane, 3'b000} +: 8];
  assign take_byte  = data_valid && data_ready;
  assign last_byte  = (cnt == 3'd1) && data_ready;
  assign rready     = (state == DATA) && (bcnt != 9'd0)
                      && (err || cnt == 3'd0 || last_byte);
  assign take_beat  = rvalid && rready;

`ifdef AXI_RD_RLAST_CHECK_EN
  assign bad = (rresp != 2'b00) || (rlast != (bcnt == 9'd1));
`else
  logic rlast_unused;
  assign rlast_unused = rlast;
  assign bad = rresp != 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      done    <= 1'b0;
      error   <= 1'b0;
      arvalid <= 1'b0;
      araddr  <= '0;
      arlen   <= '0;
      addr    <= '0;
      rem     <= '0;
      bbuf    <= '0;
      off     <= '0;
      lane    <= '0;
      cnt     <= '0;
      bcnt    <= '0;
      blen    <= '0;
      err     <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (take_byte) begin
        lane <= lane + 2'd1;
        cnt  <= cnt - 3'd1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            addr <= base_addr;
            rem  <= num_bytes;
            off  <= base_addr[1:0];
            err  <= 1'b0;
            if (num_bytes == 32'd0)
              done <= 1'b1;
            else
              state <= ADDR;
          end
        end
        ADDR: begin
          if (!arvalid) begin
            araddr  <= aligned;
            arlen   <= 8'(beats - 9'd1);
            blen    <= beats;
            bcnt    <= beats;
            arvalid <= 1'b1;
          end else if (arready) begin
            arvalid <= 1'b0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (take_beat) begin
            bcnt <= bcnt - 9'd1;
            if (bad || err) begin
              err <= 1'b1;
              cnt <= 3'd0;
            end else begin
              bbuf <= rdata;
              lane <= off;
              cnt  <= nbytes;
              rem  <= rem - {29'd0, nbytes};
              off  <= 2'd0;
            end
          end else if (bcnt == 9'd0) begin
            if (err) begin
              error <= 1'b1;
              state <= IDLE;
            end else if (rem != 32'd0) begin
              addr  <= aligned + {21'd0, blen, 2'b00};
              state <= ADDR;
            end else if (cnt == 3'd0 || last_byte) begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_burst_ctrl.sv
// Scoreboard bench for axi_read_burst_ctrl with a behavioural AXI slave.
// Expected ARs and bytes are queued at start, popped on DUT handshakes.
module tb_axi_read_burst_ctrl;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] num_bytes;
  logic        done;
  logic        error;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_ready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  axi_read_burst_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .base_addr(base_addr), .num_bytes(num_bytes),
    .done(done), .error(error),
    .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  ar_t         ar_q[$];
  ar_t         bq[$];
  logic [7:0]  exp_q[$];

  bit   ar_hs, r_hs, d_hs;
  bit   stall_prev;
  logic [7:0] stall_data;
  int   cur_idx, xfer_beat, err_beat;
  int   done_cnt, err_cnt, ar_seen, done_cyc;
  int   first_cyc, last_cyc;
  int   dr_mode;
  bit   gaps, ar_rand;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mb(input logic [31:0] a);
    return a[7:0] ^ {a[11:8], 4'h0};
  endfunction

  task automatic model_ar(input logic [31:0] base, input logic [31:0] n);
    longint rem, room, tot, b, cov;
    logic [31:0] a;
    int off;
    rem = longint'(n);
    a   = base & 32'hFFFF_FFFC;
    off = int'(base & 32'd3);
    while (rem > 0) begin
      room = (4096 - longint'(a % 4096)) / 4;
      tot  = (rem + off + 3) / 4;
      b    = tot;
      if (b > 256) b = 256;
      if (b > room) b = room;
      ar_q.push_back('{a, 8'(b - 1)});
      cov = b * 4 - off;
      rem = (rem > cov) ? rem - cov : 0;
      a   = a + 32'(b * 4);
      off = 0;
    end
  endtask

  always @(negedge clk) begin
    ar_t e;
    ar_hs = arvalid && arready;
    r_hs  = rvalid && rready;
    d_hs  = data_valid && data_ready;
    if (!reset) begin
      if (arvalid) ar_seen++;
      if (ar_hs) begin
        chk("arsize", {29'd0, arsize}, 32'd2);
        chk("arburst", {30'd0, arburst}, 32'd1);
        if (ar_q.size() == 0) begin
          chk("ar_extra", 32'd1, 32'd0);
        end else begin
          e = ar_q.pop_front();
          chk("araddr", araddr, e.addr);
          chk("arlen", {24'd0, arlen}, {24'd0, e.len});
        end
        bq.push_back('{araddr, arlen});
      end
      if (stall_prev) begin
        chk("stall_valid", {31'd0, data_valid}, 32'd1);
        chk("stall_data", {24'd0, data_out}, {24'd0, stall_data});
      end
      stall_prev = data_valid && !data_ready;
      stall_data = data_out;
      if (d_hs) begin
        if (exp_q.size() == 0)
          chk("byte_extra", 32'd1, 32'd0);
        else
          chk("byte", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      if (rready)
        chk("rready_full", {31'd0, data_valid && !data_ready}, 32'd0);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (error) err_cnt++;
      if (done || error)
        chk("done_err_excl", {31'd0, done && error}, 32'd0);
    end
  end

  always @(posedge clk) begin
    logic [31:0] a;
    #1;
    if (reset) begin
      rvalid  = 1'b0;
      rdata   = '0;
      rresp   = 2'b00;
      rlast   = 1'b0;
      arready = 1'b0;
      cur_idx = 0;
      bq.delete();
    end else begin
      if (r_hs && bq.size() > 0) begin
        xfer_beat++;
        if (cur_idx == int'(bq[0].len)) begin
          void'(bq.pop_front());
          cur_idx = 0;
        end else begin
          cur_idx++;
        end
        rvalid = 1'b0;
      end
      if (!rvalid && bq.size() > 0
          && (!gaps || $urandom_range(0, 2) != 0)) begin
        a      = bq[0].addr + 32'(cur_idx * 4);
        rdata  = {mb(a + 3), mb(a + 2), mb(a + 1), mb(a)};
        rresp  = (xfer_beat + 1 == err_beat) ? 2'b10 : 2'b00;
        rlast  = cur_idx == int'(bq[0].len);
        rvalid = 1'b1;
      end
      arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      case (dr_mode)
        0:       data_ready = 1'b1;
        1:       data_ready = !data_ready;
        default: data_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic run_xfer(input logic [31:0] base, input logic [31:0] n,
                          input int errb, input int nexp, input bit exp_err,
                          input bit poke, input bit rate);
    int st_cyc;
    done_cnt  = 0;
    err_cnt   = 0;
    ar_seen   = 0;
    xfer_beat = 0;
    err_beat  = errb;
    first_cyc = -1;
    done_cyc  = -1;
    model_ar(base, n);
    for (int i = 0; i < nexp; i++)
      exp_q.push_back(mb(base + 32'(i)));
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = base;
    num_bytes = n;
    st_cyc    = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 20000 && done_cnt + err_cnt == 0; k++) begin
      if (poke && k == 50) begin
        start     = 1'b1;
        base_addr = 32'hDEAD_0000;
        num_bytes = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (done_cnt + err_cnt == 0)
      chk("timeout", 32'd1, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("done_cnt", done_cnt, exp_err ? 32'd0 : 32'd1);
    chk("err_cnt", err_cnt, exp_err ? 32'd1 : 32'd0);
    chk("bytes_left", exp_q.size(), 32'd0);
    chk("ar_left", ar_q.size(), 32'd0);
    chk("beats_left", bq.size(), 32'd0);
    if (n == 32'd0) begin
      chk("zero_ar", ar_seen, 32'd0);
      chk("zero_lat", done_cyc, st_cyc + 1);
    end
    if (rate)
      chk("rate", last_cyc - first_cyc, n - 32'd1);
    exp_q.delete();
    ar_q.delete();
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    num_bytes  = '0;
    data_ready = 1'b0;
    dr_mode    = 0;
    gaps       = 1'b0;
    ar_rand    = 1'b0;
    err_beat   = 0;
    stall_prev = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_data", {24'd0, data_out}, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_arlen", {24'd0, arlen}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_xfer(32'h0000_1000, 32'd784, 0, 784, 1'b0, 1'b0, 1'b1);
    run_xfer(32'h0000_0000, 32'd2000, 0, 2000, 1'b0, 1'b1, 1'b0);
    run_xfer(32'h0000_0FF0, 32'd32, 0, 32, 1'b0, 1'b0, 1'b0);
    run_xfer(32'h0000_2002, 32'd5, 0, 5, 1'b0, 1'b0, 1'b0);

    dr_mode = 1;
    gaps    = 1'b1;
    ar_rand = 1'b1;
    run_xfer(32'h0000_5001, 32'd10, 0, 10, 1'b0, 1'b0, 1'b0);

    dr_mode = 2;
    run_xfer(32'h0000_3000, 32'd16, 2, 4, 1'b1, 1'b0, 1'b0);
    run_xfer(32'hFFFF_FFF9, 32'd15, 0, 15, 1'b0, 1'b0, 1'b0);

    dr_mode = 0;
    gaps    = 1'b0;
    ar_rand = 1'b0;
    run_xfer(32'h0000_4000, 32'd0, 0, 0, 1'b0, 1'b0, 1'b0);
    run_xfer(32'h0000_6003, 32'd9, 0, 9, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_read_burst_ctrl.md
Name: axi_read_burst_ctrl

Overview:
- AXI4 read master that fetches a byte-counted region of external memory using INCR bursts of 32-bit beats.
- Returns the data as a valid/ready byte stream.
- Sits under the input/weight DMA controllers, which start it, sink bytes into BRAM, and wait for done/error.

Parameters:
- MAX_BEATS, 256, maximum beats per burst (arlen ≤ MAX_BEATS-1).
- BOUNDARY, 4096, address boundary a burst never crosses (bytes).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins transfer when idle
- base_addr  in  32  byte address of first byte
- num_bytes  in  32  byte count (0 allowed)
- done  out  1  one-cycle pulse, transfer completed OK
- error  out  1  one-cycle pulse, transfer ended with AXI error
- data_out  out  8  stream byte
- data_valid  out  1  data_out valid
- data_ready  in  1  consumer accepts byte
- araddr  out  32  AR address
- arlen  out  8  beats-1
- arsize  out  3  constant 3'b010 (4 bytes)
- arburst  out  2  constant 2'b01 (INCR)
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rdata  in  32  read data, byte lane 0 = bits 7:0
- rresp  in  2  read response
- rlast  in  1  last beat
- rvalid  in  1  R valid
- rready  out  1  R ready

Behaviour:
- Single clock clk; synchronous active-high reset.
- Reset: done, error, data_valid, arvalid, rready = 0; data_out, araddr, arlen = 0; FSM → IDLE. Reset mid-transfer abandons the transaction immediately.
- IDLE: on start, latch base_addr and num_bytes.
  - num_bytes==0: done pulses the next cycle; no AR issued.
  - Otherwise go to ADDR.
  - start while not IDLE is ignored.
- ADDR:
  - araddr = current address with bits[1:0] forced to 0.
  - beats = min(ceil((remaining + lane offset)/4), MAX_BEATS, (BOUNDARY - addr%BOUNDARY)/4).
  - arlen = beats-1; arvalid held high and stable until arready; then go to DATA.
- DATA: 4-byte beat buffer.
  - rready = buffer empty, or the buffer's last valid byte is being accepted this cycle. This gives 1 byte/cycle sustained when data_ready stays high.
  - Beat accepted on rvalid&&rready.
  - Bytes are emitted lane 0→3 (little-endian).
  - First beat of the transfer starts at lane base_addr[1:0].
  - Final beat stops after the remaining byte count; unused lanes are discarded.
- Stream: data_valid/data_out change only when data_valid==0 or data_ready==1; data_out is stable while stalled. A byte transfers on data_valid&&data_ready.
- Burst end: after the beat counter reaches arlen+1:
  - bytes remaining → advance address by beats×4 and return to ADDR;
  - otherwise wait until the last byte is accepted, then pulse done the following cycle and return to IDLE.
- Error:
  - Any beat with rresp≠2'b00 sets a sticky error flag.
  - Remaining beats of the current burst are drained (rready=1, bytes discarded, data_valid=0).
  - Then error pulses for one cycle, done stays 0, FSM returns to IDLE. No further bursts issue.
- done and error never assert in the same cycle. Exactly one of them pulses per accepted start.
- Counters are 32-bit. Address wraps modulo 2^32. No error on wrap.

Optional Feature:
- Macro AXI_RD_RLAST_CHECK_EN.
- Defined: rlast must be 1 exactly on the final counted beat of each burst. Early or missing rlast is treated as an error response (drain, then error pulse).
- Undefined: rlast is ignored; the internal beat counter alone ends the burst.

Test Plan:
- base 0x1000, num_bytes 784, arready/rvalid always 1, data_ready 1 → one AR (araddr 0x1000, arlen 195), 784 bytes in address order, 1 byte/cycle, single done pulse, error 0.
- base 0x0000, num_bytes 2000 → ARs at 0x0000 arlen 255 and 0x0400 arlen 243. Byte count 2000, then done.
- base 0x0FF0, num_bytes 32 → 4KB split: AR 0x0FF0 arlen 3, then AR 0x1000 arlen 3. Bytes are contiguous.
- base 0x2002, num_bytes 5, memory bytes 0x00..0x0F at 0x2000 → AR 0x2000 arlen 1; stream 02,03,04,05,06; done.
- data_ready toggling 1-0 every cycle, random rvalid gaps, num_bytes 10 → data_out stable across stalls, 10 bytes correct, rready never high with full buffer.
- rresp=2'b10 on beat 2 of a 4-beat burst → beats 3–4 drained, one error pulse, no done. num_bytes 0 → done next cycle, arvalid never asserted.
